if_id_buf: RTL and testbench
============================

# if_id_buf

Fetch-to-decode pipeline stage with a small instruction queue. It sits between the instruction-fetch bus and the decode stage, and presents one instruction per cycle to decode. It absorbs fetch returns while decode is stalled, so the fetch bus need not be re-issued. On a jump/flush hold it discards all wrong-path instructions.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- inst_i  in  32  fetched instruction
- inst_addr_i  in  32  address of inst_i
- inst_valid_i  in  1  inst_i/inst_addr_i/prdt_taken_i valid this cycle
- prdt_taken_i  in  1  branch predictor taken flag for inst_i
- hold_flag_i  in  `Hold_Flag_Bus  pipeline hold; flush when ≥ `Hold_If
- stall_flag_i  in  1  decode stall (load-use); output must hold
- inst_o  out  32  instruction to decode
- inst_addr_o  out  32  address to decode
- prdt_taken_o  out  1  prediction flag to decode
- inst_valid_o  out  1  inst_o is a real instruction
- fetch_ready_o  out  1  queue not full; PC may issue a fetch
- level_o  out  $clog2(DEPTH+1)  current queue occupancy
- ovf_o  out  1  sticky: valid fetch arrived while queue full

## Operation
- Reset (rst=0 at posedge): inst_o=`INST_NOP, inst_addr_o=`ZeroWord, prdt_taken_o=0, inst_valid_o=0, level_o=0, ovf_o=0, pointers 0.
- Per cycle, decided in priority order:
  1. Flush (hold_flag_i ≥ `Hold_If):
     - outputs take their reset values; queue emptied (level 0, pointers 0).
     - inst_valid_i is discarded.
     - Flush overrides stall.
  2. Stall (stall_flag_i=1):
     - outputs hold.
     - If inst_valid_i and level<DEPTH: push to tail.
     - If inst_valid_i and level=DEPTH: drop the fetch, set ovf_o.
  3. Advance:
     - Output register loads the queue head (pop) if level>0; otherwise inst_i directly if inst_valid_i (bypass); otherwise NOP with valid=0, addr 0, prdt 0.
     - If level>0 and inst_valid_i: push and pop in the same cycle; level unchanged.
- Queue entry is {inst, addr, prdt}, 65 bits. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- level counts 0..DEPTH; it never exceeds DEPTH and never underflows.
- fetch_ready_o = (level_o != DEPTH). It is a combinational function of registered state only, with no input-to-output path.
- ovf_o is cleared only by reset.

## Timing
- Bypass latency: fetch at cycle N → inst_o at N+1.
- Queued instruction: appears at inst_o in the first non-stalled, non-flushed cycle, in FIFO order.
- Stall release with level=k: k queued instructions emerge on k consecutive cycles, followed by any new fetches, with no bubble.
- fetch_ready_o drops the cycle after the push that fills the queue. A fetch accepted in the filling cycle is legal.
- A flush in cycle N gives inst_valid_o=0 at N+1 and fetch_ready_o=1 at N+1.
- Reset mid-operation discards all queued entries identically to a flush, and also clears ovf_o.

## Structure
- Uses the shared defines header for `InstBus, `InstAddrBus, `Hold_Flag_Bus, `Hold_If, `INST_NOP, `ZeroWord. No new package constants are needed.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/flush, level output), instantiated with width 65.
- The output register and the priority logic live in if_id_buf.

## Test plan
- Reset: hold rst=0 for 2 cycles with inst_valid_i=1 → inst_o=0x00000013, inst_valid_o=0, level_o=0, fetch_ready_o=1, ovf_o=0.
- Streaming: fetch addrs 0x0,0x4,0x8 back-to-back, no stall → inst_addr_o 0x0,0x4,0x8 on the following three cycles; level_o stays 0.
- Stall absorb: stall 2 cycles while fetching 0x10,0x14 → level_o goes 1 then 2, fetch_ready_o=0. After release, 0x10 then 0x14 appear on consecutive cycles, then the next fetch 0x18.
- Overflow: DEPTH=2, queue full, stall held, inst_valid_i=1 with addr 0x20 → 0x20 is never output, ovf_o=1 and stays 1.
- Flush during stall: level_o=2, stall_flag_i=1 and hold_flag_i=`Hold_If with a valid fetch → next cycle inst_valid_o=0, inst_o=NOP, level_o=0. The next fetch 0x100 appears one cycle later.
- Simultaneous push/pop: level_o=1 holding 0x30, no stall, fetch 0x34 → inst_addr_o=0x30, level_o stays 1. The following cycle outputs 0x34.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// Shared pipeline defines plus the queue-entry type used by the fetch/decode buffer.
// Guarded so the file may be compiled directly and also included by its users.
`ifndef IF_ID_BUF_PKG_SV
`define IF_ID_BUF_PKG_SV

`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef Hold_Flag_Bus
`define Hold_Flag_Bus 2:0
`endif
`ifndef Hold_If
`define Hold_If 3'b010
`endif
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

package if_id_buf_pkg;

    typedef struct packed {
        logic [`InstBus]     inst;
        logic [`InstAddrBus] addr;
        logic                prdt;
    } if_entry_t;

    localparam int ENTRY_W = $bits(if_entry_t);

    localparam if_entry_t NOP_ENTRY = '{inst: `INST_NOP, addr: `ZeroWord, prdt: 1'b0};

endpackage

`endif

// File: rtl/if_id_buf_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy output; head is read combinationally.
// Pushes are accepted when not full, or when full but popping in the same cycle.
`include "if_id_buf_pkg.sv"

module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pop_ok   = pop && (level_q != '0);
        push_ok  = push && ((level_q != LVL_W'(DEPTH)) || pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode stage: output register fed by a bypass path or a small instruction queue.
// Priority each cycle is flush, then stall, then advance.
`include "if_id_buf_pkg.sv"

module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`InstBus]            inst_i,
    input  logic [`InstAddrBus]        inst_addr_i,
    input  logic                       inst_valid_i,
    input  logic                       prdt_taken_i,
    input  logic [`Hold_Flag_Bus]      hold_flag_i,
    input  logic                       stall_flag_i,
    output logic [`InstBus]            inst_o,
    output logic [`InstAddrBus]        inst_addr_o,
    output logic                       prdt_taken_o,
    output logic                       inst_valid_o,
    output logic                       fetch_ready_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       ovf_o
);
    localparam int LVL_W = $clog2(DEPTH+1);

    if_entry_t        out_q, out_d;
    if_entry_t        in_entry;
    if_entry_t        head;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, flush;
    logic             full, empty;
    logic [LVL_W-1:0] level;
    logic [ENTRY_W-1:0] head_raw;

    assign in_entry = '{inst: inst_i, addr: inst_addr_i, prdt: prdt_taken_i};
    assign head     = if_entry_t'(head_raw);
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_entry),
        .rdata (head_raw),
        .level (level)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (hold_flag_i >= `Hold_If) begin
            flush   = 1'b1;
            out_d   = NOP_ENTRY;
            valid_d = 1'b0;
        end else if (stall_flag_i) begin
            if (inst_valid_i) begin
                if (!full) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end else if (!empty) begin
            // Queue drains first to keep FIFO order; a new fetch backfills the tail.
            pop     = 1'b1;
            push    = inst_valid_i;
            out_d   = head;
            valid_d = 1'b1;
        end else if (inst_valid_i) begin
            out_d   = in_entry;
            valid_d = 1'b1;
        end else begin
            out_d   = NOP_ENTRY;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q   <= NOP_ENTRY;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign inst_o        = out_q.inst;
    assign inst_addr_o   = out_q.addr;
    assign prdt_taken_o  = out_q.prdt;
    assign inst_valid_o  = valid_q;
    assign level_o       = level;
    assign fetch_ready_o = !full;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed vector table, then random traffic against a queue model.
module tb_if_id_buf;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i;
    logic        inst_valid_i, prdt_taken_i, stall_flag_i;
    logic [2:0]  hold_flag_i;
    logic [31:0] inst_o, inst_addr_o;
    logic        prdt_taken_o, inst_valid_o, fetch_ready_o, ovf_o;
    logic [1:0]  level_o;

    int total = 0;
    int bad   = 0;

    if_id_buf #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_i        (inst_i),
        .inst_addr_i   (inst_addr_i),
        .inst_valid_i  (inst_valid_i),
        .prdt_taken_i  (prdt_taken_i),
        .hold_flag_i   (hold_flag_i),
        .stall_flag_i  (stall_flag_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .prdt_taken_o  (prdt_taken_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_ready_o (fetch_ready_o),
        .level_o       (level_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic prdt_of(input logic [31:0] a);
        return a[2];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue plus output register contents.
    typedef struct { logic [31:0] inst; logic [31:0] addr; logic prdt; } ent_t;
    ent_t        mq[$];
    ent_t        m_out;
    logic        m_valid;
    logic        m_ovf;

    task automatic model_step();
        ent_t e;
        e.inst = inst_i; e.addr = inst_addr_i; e.prdt = prdt_taken_i;
        if (!rst || hold_flag_i >= 3'd2) begin
            mq.delete();
            m_out   = '{32'h13, 32'h0, 1'b0};
            m_valid = 1'b0;
            if (!rst) m_ovf = 1'b0;
        end else if (stall_flag_i) begin
            if (inst_valid_i) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1'b1;
            end
        end else if (mq.size() > 0) begin
            m_out   = mq.pop_front();
            m_valid = 1'b1;
            if (inst_valid_i) mq.push_back(e);
        end else if (inst_valid_i) begin
            m_out   = e;
            m_valid = 1'b1;
        end else begin
            m_out   = '{32'h13, 32'h0, 1'b0};
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [31:0] a,
                         input logic st, input logic [2:0] h);
        rst          = r;
        inst_valid_i = iv;
        inst_addr_i  = a;
        inst_i       = inst_of(a);
        prdt_taken_i = prdt_of(a);
        stall_flag_i = st;
        hold_flag_i  = h;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        r, iv, st;
        logic [31:0] a;
        logic [2:0]  h;
        logic        ev;
        logic [31:0] ea;
        int          lvl;
        logic        rdy, ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r, input logic iv, input logic [31:0] a,
                               input logic st, input logic [2:0] h, input logic ev,
                               input logic [31:0] ea, input int lvl, input logic rdy,
                               input logic ovf);
        vec_t x;
        x.r = r; x.iv = iv; x.a = a; x.st = st; x.h = h;
        x.ev = ev; x.ea = ea; x.lvl = lvl; x.rdy = rdy; x.ovf = ovf;
        return x;
    endfunction

    initial begin
        //             r  iv addr     st h     ev ea       lvl rdy ovf
        vt.push_back(v(0, 1, 32'h40,  0, 0,    0, 32'h0,   0,  1,  0)); // reset
        vt.push_back(v(0, 1, 32'h44,  0, 0,    0, 32'h0,   0,  1,  0));
        vt.push_back(v(1, 1, 32'h0,   0, 0,    1, 32'h0,   0,  1,  0)); // streaming
        vt.push_back(v(1, 1, 32'h4,   0, 0,    1, 32'h4,   0,  1,  0));
        vt.push_back(v(1, 1, 32'h8,   0, 0,    1, 32'h8,   0,  1,  0));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    0, 32'h0,   0,  1,  0));
        vt.push_back(v(1, 1, 32'hC,   0, 0,    1, 32'hC,   0,  1,  0)); // stall absorb
        vt.push_back(v(1, 1, 32'h10,  1, 0,    1, 32'hC,   1,  1,  0));
        vt.push_back(v(1, 1, 32'h14,  1, 0,    1, 32'hC,   2,  0,  0));
        vt.push_back(v(1, 1, 32'h18,  0, 0,    1, 32'h10,  2,  0,  0));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    1, 32'h14,  1,  1,  0));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    1, 32'h18,  0,  1,  0));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    0, 32'h0,   0,  1,  0));
        vt.push_back(v(1, 1, 32'h1C,  1, 0,    0, 32'h0,   1,  1,  0)); // overflow
        vt.push_back(v(1, 1, 32'h28,  1, 0,    0, 32'h0,   2,  0,  0));
        vt.push_back(v(1, 1, 32'h20,  1, 0,    0, 32'h0,   2,  0,  1));
        vt.push_back(v(1, 0, 32'h0,   1, 0,    0, 32'h0,   2,  0,  1));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    1, 32'h1C,  1,  1,  1));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    1, 32'h28,  0,  1,  1));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    0, 32'h0,   0,  1,  1));
        vt.push_back(v(1, 1, 32'h50,  1, 0,    0, 32'h0,   1,  1,  1)); // flush in stall
        vt.push_back(v(1, 1, 32'h54,  1, 0,    0, 32'h0,   2,  0,  1));
        vt.push_back(v(1, 1, 32'h60,  1, 2,    0, 32'h0,   0,  1,  1));
        vt.push_back(v(1, 1, 32'h100, 0, 0,    1, 32'h100, 0,  1,  1));
        vt.push_back(v(1, 1, 32'h104, 0, 0,    1, 32'h104, 0,  1,  1));
        vt.push_back(v(1, 1, 32'h108, 0, 3,    0, 32'h0,   0,  1,  1)); // hold above If
        vt.push_back(v(1, 1, 32'h10C, 0, 1,    1, 32'h10C, 0,  1,  1)); // hold below If
        vt.push_back(v(1, 1, 32'h30,  1, 0,    1, 32'h10C, 1,  1,  1)); // push+pop
        vt.push_back(v(1, 1, 32'h34,  0, 0,    1, 32'h30,  1,  1,  1));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    1, 32'h34,  0,  1,  1));
        vt.push_back(v(1, 1, 32'h70,  1, 0,    1, 32'h34,  1,  1,  1)); // mid-run reset
        vt.push_back(v(0, 1, 32'h74,  0, 0,    0, 32'h0,   0,  1,  0));
        vt.push_back(v(1, 0, 32'h0,   0, 0,    0, 32'h0,   0,  1,  0));

        m_out = '{32'h13, 32'h0, 1'b0};
        m_valid = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].r, vt[i].iv, vt[i].a, vt[i].st, vt[i].h);
            chk($sformatf("vec%0d valid", i), {31'd0, inst_valid_o}, {31'd0, vt[i].ev});
            chk($sformatf("vec%0d addr", i), inst_addr_o, vt[i].ea);
            chk($sformatf("vec%0d inst", i), inst_o, vt[i].ev ? inst_of(vt[i].ea) : 32'h13);
            chk($sformatf("vec%0d prdt", i), {31'd0, prdt_taken_o},
                {31'd0, vt[i].ev ? prdt_of(vt[i].ea) : 1'b0});
            chk($sformatf("vec%0d level", i), {30'd0, level_o}, vt[i].lvl);
            chk($sformatf("vec%0d ready", i), {31'd0, fetch_ready_o}, {31'd0, vt[i].rdy});
            chk($sformatf("vec%0d ovf", i), {31'd0, ovf_o}, {31'd0, vt[i].ovf});
        end

        for (int n = 0; n < 600; n++) begin
            logic        r, iv, st;
            logic [2:0]  h;
            logic [31:0] a;
            r  = ($urandom_range(0, 99) >= 2);
            iv = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 99) < 40);
            h  = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            a  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(r, iv, a, st, h);
            chk("rnd valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
            chk("rnd inst", inst_o, m_out.inst);
            chk("rnd addr", inst_addr_o, m_out.addr);
            chk("rnd prdt", {31'd0, prdt_taken_o}, {31'd0, m_out.prdt});
            chk("rnd level", {30'd0, level_o}, mq.size());
            chk("rnd ready", {31'd0, fetch_ready_o}, {31'd0, mq.size() != DEPTH});
            chk("rnd ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
